// File: rtl/circuit_pkg.sv
// circuit_pkg: shared types, constants and golden model for the NAND-block sweep controller
//   state_e         sweep FSM states
//   VEC_MAX         last input vector of the sweep
//   MISR_W          signature register width
//   circuit_golden  expected {y3,y2,y1} for input vector x (x[0]=x1 .. x[7]=x8)
package circuit_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

   localparam logic [7:0] VEC_MAX = 8'hFF;
   localparam int         MISR_W  = 16;

   function automatic logic [2:0] circuit_golden(input logic [7:0] x);
      return {~((x[4] | x[5]) & (x[6] | x[7])),
              ~((x[2] | x[3]) & (x[6] | x[7])),
              ~((x[1] | x[3]) & (x[5] | x[7]))};
   endfunction

endpackage

// File: rtl/circuit_misr.sv
// circuit_misr: multiple-input signature register compacting the 3-bit DUT response
//   clk, rst_n  clock, asynchronous active-low reset (loads MISR_SEED)
//   en_i        shift in d_i this cycle
//   load_i      reload MISR_SEED (wins over en_i)
//   d_i         3-bit response folded into the low bits
//   sig_o       current signature
module circuit_misr
   import circuit_pkg::*;
#(
   parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
   parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              load_i,
   input  logic [2:0]        d_i,
   output logic [MISR_W-1:0] sig_o
);

   logic [MISR_W-1:0] sig_q, sig_d;

   always_comb
      sig_d = load_i ? MISR_SEED
            : en_i   ? ({sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                        ^ {{(MISR_W-3){1'b0}}, d_i})
            : sig_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sig_q <= MISR_SEED;
      else        sig_q <= sig_d;

   assign sig_o = sig_q;

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// circuit_sweep_ctrl: exhaustive 256-vector self-test sequencer for the 8-in/3-out NAND block
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           begin a sweep (only honoured in IDLE, abort_i wins)
//   abort_i           drop back to IDLE from DRIVE/SAMPLE without a done pulse
//   x_o               vector driven to the block under test
//   y_in_i            block outputs {y3,y2,y1}
//   busy_o            sweep in progress
//   done_o            one-cycle completion pulse
//   mismatch_cnt_o    number of failing vectors
//   fail_valid_o      at least one failing vector seen
//   first_fail_vec_o  first failing vector
//   signature_o       MISR over every sampled response
module circuit_sweep_ctrl
   import circuit_pkg::*;
#(
   parameter int                SETTLE_CYCLES = 2,
   parameter logic [MISR_W-1:0] MISR_POLY     = 16'h1021,
   parameter logic [MISR_W-1:0] MISR_SEED     = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [7:0]        x_o,
   input  logic [2:0]        y_in_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [8:0]        mismatch_cnt_o,
   output logic              fail_valid_o,
   output logic [7:0]        first_fail_vec_o,
   output logic [MISR_W-1:0] signature_o
);

   state_e     state_q;
   logic [7:0] x_q, ffv_q;
   logic [3:0] settle_q;
   logic [8:0] cnt_q;
   logic       busy_q, done_q, fv_q;
   logic       accept, kill, sample, miss;

   assign accept = (state_q == IDLE) && start_i && !abort_i;
   assign kill   = abort_i && ((state_q == DRIVE) || (state_q == SAMPLE));
   // an aborted SAMPLE must not leak into the counters or the signature
   assign sample = (state_q == SAMPLE) && !abort_i;
   assign miss   = y_in_i != circuit_golden(x_q);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         fv_q     <= 1'b0;
         ffv_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (kill) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            settle_q <= '0;
         end else
            case (state_q)
               IDLE:
                  if (accept) begin
                     state_q  <= DRIVE;
                     x_q      <= '0;
                     settle_q <= '0;
                     busy_q   <= 1'b1;
                     cnt_q    <= '0;
                     fv_q     <= 1'b0;
                     ffv_q    <= '0;
                  end
               DRIVE:
                  if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                     state_q  <= SAMPLE;
                     settle_q <= '0;
                  end else
                     settle_q <= settle_q + 4'd1;
               SAMPLE: begin
                  if (miss) begin
                     cnt_q <= cnt_q + 9'd1;
                     if (!fv_q) begin
                        fv_q  <= 1'b1;
                        ffv_q <= x_q;
                     end
                  end
                  if (x_q == VEC_MAX) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     x_q     <= x_q + 8'd1;
                     state_q <= DRIVE;
                  end
               end
               default: state_q <= IDLE;
            endcase
      end

   circuit_misr #(
      .MISR_POLY(MISR_POLY),
      .MISR_SEED(MISR_SEED)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (sample),
      .load_i(accept),
      .d_i   (y_in_i),
      .sig_o (signature_o)
   );

   assign x_o              = x_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign mismatch_cnt_o   = cnt_q;
   assign fail_valid_o     = fv_q;
   assign first_fail_vec_o = ffv_q;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// tb_circuit_sweep_ctrl: randomized self-checking bench for circuit_sweep_ctrl
module tb_circuit_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start, abort;
   logic [7:0]  x, ffv;
   logic [2:0]  y;
   logic        busy, done, fv;
   logic [8:0]  cnt;
   logic [15:0] sig;

   logic        start1;
   logic [7:0]  x1, ffv1;
   logic [2:0]  y1;
   logic        busy1, done1, fv1;
   logic [8:0]  cnt1;
   logic [15:0] sig1;

   int          mode;
   logic [2:0]  flip [256];
   int          n_chk = 0;
   int          n_pass = 0;

   circuit_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .x_o(x), .y_in_i(y),
      .busy_o(busy), .done_o(done), .mismatch_cnt_o(cnt), .fail_valid_o(fv),
      .first_fail_vec_o(ffv), .signature_o(sig)
   );

   circuit_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(1'b0), .x_o(x1), .y_in_i(y1),
      .busy_o(busy1), .done_o(done1), .mismatch_cnt_o(cnt1), .fail_valid_o(fv1),
      .first_fail_vec_o(ffv1), .signature_o(sig1)
   );

   // reference NAND block: y1 = NOT((x2 OR x4) AND (x6 OR x8)) etc.
   function automatic logic [2:0] gold(input int v);
      bit b2, b3, b4, b5, b6, b7, b8;
      b2 = (v / 2) % 2 == 1;  b3 = (v / 4) % 2 == 1;  b4 = (v / 8) % 2 == 1;
      b5 = (v / 16) % 2 == 1; b6 = (v / 32) % 2 == 1; b7 = (v / 64) % 2 == 1;
      b8 = (v / 128) % 2 == 1;
      return {!((b5 || b6) && (b7 || b8)), !((b3 || b4) && (b7 || b8)), !((b2 || b4) && (b6 || b8))};
   endfunction

   function automatic logic [2:0] resp_of(input int m, input int v);
      if (m == 0) return gold(v);
      if (m == 1) return gold(v) & 3'b110;
      return gold(v) ^ flip[v];
   endfunction

   always_comb y  = (mode == 0) ? gold(int'(x)) : (mode == 1) ? (gold(int'(x)) & 3'b110) : (gold(int'(x)) ^ flip[x]);
   always_comb y1 = gold(int'(x1));

   function automatic int misr_step(input int s, input logic [2:0] r);
      int t;
      t = (s * 2) % 65536;
      if (s >= 32768) t = t ^ 'h1021;
      return t ^ int'(r);
   endfunction

   task automatic model(input int m, input int upto, output int ec, output int ef, output int efv, output int es);
      logic [2:0] r;
      ec = 0; ef = 0; efv = 0; es = 'hFFFF;
      for (int v = 0; v < upto; v++) begin
         r = resp_of(m, v);
         if (r != gold(v)) begin
            if (ef == 0) efv = v;
            ef = 1;
            ec++;
         end
         es = misr_step(es, r);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic check_results(input string tag, input int m, input int upto);
      int ec, ef, efv, es;
      model(m, upto, ec, ef, efv, es);
      chk({tag, "_cnt"}, 32'(cnt), ec);
      chk({tag, "_fv"}, 32'(fv), ef);
      if (ef != 0) chk({tag, "_ffv"}, 32'(ffv), efv);
      chk({tag, "_sig"}, 32'(sig), es);
   endtask

   // cycle 1 is the first cycle after the accepting edge
   task automatic sweep(input int m, input bit hold, output int cyc, output int pulses);
      mode = m;
      @(negedge clk); start = 1'b1;
      @(negedge clk); if (!hold) start = 1'b0;
      cyc = 1; pulses = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk); cyc++;
      end
      start = 1'b0;
      if (done) pulses = 1;
   endtask

   task automatic abort_at(input int av, input int ph);
      int n = 0, dn = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (x != av[7:0] && n < 2000) begin @(negedge clk); n++; end
      chk("abort_reach", 32'(x), av);
      repeat (ph) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_x", 32'(x), av);
      check_results("abort", mode, av);
      repeat (10) begin @(negedge clk); dn += int'(done); end
      chk("abort_nodone", dn, 0);
   endtask

   initial begin
      int cyc, pulses, sig_good, prev, run, bad, n;
      start = 1'b0; abort = 1'b0; start1 = 1'b0; mode = 0;
      foreach (flip[i]) flip[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_x", 32'(x), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_fv", 32'(fv), 0);
      chk("rst_ffv", 32'(ffv), 0);
      chk("rst_sig", 32'(sig), 'hFFFF);
      rst_n = 1'b1;

      // fault-free sweep
      sweep(0, 1'b0, cyc, pulses);
      chk("good_cycles", cyc, 769);
      chk("good_x", 32'(x), 'hFF);
      chk("good_busy", 32'(busy), 0);
      check_results("good", 0, 256);
      sig_good = int'(sig);
      @(negedge clk);
      chk("done_width", 32'(done), 0);
      repeat (5) @(negedge clk);
      check_results("hold", 0, 256);

      // y1 stuck-at-0
      sweep(1, 1'b0, cyc, pulses);
      chk("sa0_cnt_abs", 32'(cnt), 112);
      chk("sa0_ffv_abs", 32'(ffv), 0);
      chk("sa0_sig_differs", 32'(int'(sig) != sig_good), 1);
      check_results("sa0", 1, 256);

      // random response corruption
      for (int k = 0; k < 2; k++) begin
         sweep(2, 1'b0, cyc, pulses);
         chk("rand_cycles", cyc, 769);
         check_results("rand", 2, 256);
         foreach (flip[i]) flip[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      end

      // start held high for the whole sweep
      sweep(0, 1'b1, cyc, pulses);
      chk("hold_cycles", cyc, 769);
      chk("hold_pulses", pulses, 1);
      n = 0;
      repeat (6) begin @(negedge clk); n += int'(busy) + int'(done); end
      chk("hold_norestart", n, 0);

      // abort has priority over start in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk("abort_prio", 32'(busy), 0);

      // aborts
      mode = 2;
      abort_at('h0A, 0);
      for (int k = 0; k < 3; k++) abort_at(int'($urandom_range(1, 254)), int'($urandom_range(0, 2)));

      // asynchronous reset mid-sweep, then a clean restart
      mode = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (x != 8'h40 && n < 2000) begin @(negedge clk); n++; end
      chk("rst_reach", 32'(x), 'h40);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_x", 32'(x), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_cnt", 32'(cnt), 0);
      chk("arst_fv", 32'(fv), 0);
      chk("arst_sig", 32'(sig), 'hFFFF);
      @(negedge clk); rst_n = 1'b1;
      sweep(2, 1'b0, cyc, pulses);
      chk("restart_cycles", cyc, 769);
      check_results("restart", 2, 256);

      // SETTLE_CYCLES = 1 instance
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      cyc = 1; prev = int'(x1); run = 1; bad = 0;
      while (!done1 && cyc < 2000) begin
         @(negedge clk); cyc++;
         if (busy1) begin
            if (int'(x1) == prev) run++;
            else begin
               if (run != 2) bad++;
               prev = int'(x1); run = 1;
            end
         end
      end
      if (run != 2) bad++;
      chk("s1_cycles", cyc, 513);
      chk("s1_runs", bad, 0);
      chk("s1_cnt", 32'(cnt1), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
